guard_issue_ctrl: RTL and testbench

//  Upstream issue stage for the guarded (operand-isolated) 32-bit adder stage. Buffers operand

---
 rtl/guard_issue_ctrl_pkg.sv | 14 +
 rtl/guard_issue_ctrl_op_fifo.sv | 51 +++++
 rtl/guard_issue_ctrl.sv | 94 +++++++++
 tb/tb_guard_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/guard_issue_ctrl_pkg.sv
// Shared types and defaults for the guarded-adder issue stage.
package guard_issue_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_PTR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/guard_issue_ctrl_op_fifo.sv
// Operand-pair FIFO: synchronous, no bypass, head visible one cycle after push.
module guard_issue_ctrl_op_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DW-1:0]    wdata,
  input  logic             pop,
  output logic [DW-1:0]    rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally at PTR_W bits since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/guard_issue_ctrl.sv
// Issue stage for the operand-isolated adder: buffers pairs, drives operands/guard, registers sum.
//   state | meaning
//   IDLE  | no add in flight; operands frozen, guard low
//   ISSUE | operands valid at adder, guard high, sum captured if result slot free
//   HOLD  | result slot full; operands retained, guard low until consumer drains
module guard_issue_ctrl
  import guard_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] eval_a,
  output logic [WIDTH-1:0] eval_b,
  output logic             eval_sel,
  output logic [WIDTH-1:0] eval_in,
  input  logic [WIDTH-1:0] eval_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [PTR_W:0]   fifo_cnt
);

  state_t             state;
  logic               full;
  logic               empty;
  logic               pop;
  logic               slot_free;
  logic [2*WIDTH-1:0] head;

  assign in_ready  = !full;
  assign slot_free = !res_valid || res_ready;
  assign eval_sel  = (state == ST_ISSUE);
  assign eval_in   = res_data;
  assign pop       = !empty && ((state == ST_IDLE) || ((state == ST_ISSUE) && slot_free));

  guard_issue_ctrl_op_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      eval_a    <= '0;
      eval_b    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // A capture below overrides this clear when both happen together.
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (pop) begin
        eval_a <= head[2*WIDTH-1:WIDTH];
        eval_b <= head[WIDTH-1:0];
      end
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (slot_free) begin
            res_data  <= eval_y;
            res_valid <= 1'b1;
            state     <= empty ? ST_IDLE : ST_ISSUE;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (slot_free) state <= ST_ISSUE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guard_issue_ctrl.sv
// Bench for guard_issue_ctrl: directed steps plus random traffic against an in-order sum queue.
module tb_guard_issue_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] eval_a;
  logic [W-1:0] eval_b;
  logic         eval_sel;
  logic [W-1:0] eval_in;
  logic [W-1:0] eval_y;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   fifo_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sel_cnt = 0;
  int sel_run = 0;
  int sel_max = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  guard_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .eval_a    (eval_a),
    .eval_b    (eval_b),
    .eval_sel  (eval_sel),
    .eval_in   (eval_in),
    .eval_y    (eval_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .fifo_cnt  (fifo_cnt)
  );

  // Guarded adder stage: adds only when selected, otherwise passes eval_in through.
  assign eval_y = eval_sel ? (eval_a + eval_b) : eval_in;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Record the handshakes the coming edge will see, then advance one cycle.
  task automatic tick();
    if (in_valid && in_ready) begin
      exp_q.push_back(in_a + in_b);
      last_a = in_a;
      last_b = in_b;
    end
    if (res_valid && res_ready) begin
      got_q.push_back(res_data);
      got_cyc.push_back(cyc);
    end
    if (eval_sel) begin
      sel_cnt++;
      sel_run++;
      if (sel_run > sel_max) sel_max = sel_run;
    end else begin
      sel_run = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    sel_cnt = 0;
    sel_run = 0;
    sel_max = 0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("result_count", got_q.size(), n);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk(tag, got_q.pop_front(), exp_q.pop_front());
    clear_model();
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] sum, input string tag);
    clear_model();
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    tick();
    in_valid = 1'b0;
    wait_res(1, 10);
    if (got_q.size() > 0) chk(tag, got_q[0], sum);
    check_order({tag, "_sb"});
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    #12;
    chk("rst_eval_a", eval_a, 0);
    chk("rst_eval_b", eval_b, 0);
    chk("rst_eval_sel", 32'(eval_sel), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // 5+7: guard high exactly one cycle, sum two edges after accept.
    clear_model();
    res_ready = 1'b1; in_valid = 1'b1; in_a = 5; in_b = 7;
    tick();
    in_valid = 1'b0;
    chk("lat_sel_e1", 32'(eval_sel), 0);
    chk("lat_cnt_e1", 32'(fifo_cnt), 1);
    tick();
    chk("lat_sel_e2", 32'(eval_sel), 1);
    chk("lat_eval_a", eval_a, 5);
    chk("lat_eval_b", eval_b, 7);
    chk("lat_valid_e2", 32'(res_valid), 0);
    tick();
    chk("lat_valid_e3", 32'(res_valid), 1);
    chk("lat_data_e3", res_data, 12);
    chk("lat_sel_e3", 32'(eval_sel), 0);
    tick();
    chk("lat_valid_clr", 32'(res_valid), 0);
    tick(); tick();
    chk("lat_sel_cnt", sel_cnt, 1);
    check_order("lat_sb");

    single(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, "wrap1");
    single(32'h8000_0000, 32'h8000_0000, 32'h0, "wrap2");

    // Back-to-back: one result per cycle.
    clear_model();
    res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_a = W'(i); in_b = W'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_res(4, 12);
    chk("b2b_sel_run", sel_max, 4);
    chk("b2b_sel_cnt", sel_cnt, 4);
    for (int i = 0; i < got_q.size(); i++) begin
      chk("b2b_data", got_q[i], W'(2 * (i + 1)));
      chk("b2b_consec", got_cyc[i] - got_cyc[0], i);
    end
    check_order("b2b_sb");

    // Stall: DEPTH + operand reg + result reg = 6 accepts.
    clear_model();
    res_ready = 1'b0; in_valid = 1'b1; k = 0;
    while (in_ready && k < 20) begin
      in_a = $urandom; in_b = $urandom;
      tick();
      k++;
    end
    chk("cap_accepts", exp_q.size(), 6);
    chk("cap_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    tick(); tick();
    chk("cap_state_hold", 32'(dut.state), 2);
    chk("cap_sel", 32'(eval_sel), 0);
    chk("cap_fifo_cnt", 32'(fifo_cnt), 4);
    chk("cap_res_valid", 32'(res_valid), 1);
    res_ready = 1'b1;
    wait_res(6, 40);
    check_order("cap_sb");
    tick();
    chk("cap_state_idle", 32'(dut.state), 0);

    // Idle: operands frozen at last loaded pair while inputs toggle.
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_a = $urandom; in_b = $urandom;
      tick();
      chk("idle_eval_a", eval_a, last_a);
      chk("idle_eval_b", eval_b, last_b);
      chk("idle_sel", 32'(eval_sel), 0);
    end

    // Random traffic, then drain.
    clear_model();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_b      = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; res_ready = 1'b1;
    wait_res(exp_q.size(), 40);
    check_order("rand_sb");

    // Async reset in the middle of back-to-back issue.
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = W'(100 + i); in_b = W'(i);
      tick();
    end
    chk("mid_sel_pre", 32'(eval_sel), 1);
    #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("arst_eval_a", eval_a, 0);
    chk("arst_eval_b", eval_b, 0);
    chk("arst_sel", 32'(eval_sel), 0);
    chk("arst_res_valid", 32'(res_valid), 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_fifo_cnt", 32'(fifo_cnt), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    single(32'd9, 32'd1, 32'd10, "post_rst");
    tick(); tick();
    chk("post_rst_stale", got_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
